// File: rtl/ula_entrada_ctrl.sv
// ula_entrada_ctrl: push-button conditioning and operand/selector registers
// feeding the ULA datapath. KEY[0] steps the operation selector (0..6) and
// KEY[1] captures A, B and carry-in from the switches. Keys are active-low,
// synchronized, then debounced by a three-state FSM per key.
// Optional feature: define ULA_AUTO_REPEAT_EN to auto-step the selector
// every REPEAT_CYCLES while KEY[0] stays held.
module ula_entrada_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] SW,
  input  logic [1:0] KEY,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  output logic       cin_out,
  output logic [2:0] seletor_out,
  output logic       op_pulse,
  output logic       load_pulse
);

  typedef enum logic [1:0] {
    ST_STABLE,
    ST_COUNT,
    ST_COMMIT
  } deb_state_e;

  logic [1:0] sync1_q, sync2_q;
  logic [1:0] ks;     // synchronized keys, 1 = pressed
  logic [1:0] deb;    // debounced level per key
  logic [1:0] press;  // one-cycle press strobe per key
  logic       repeat_step;
  logic       step;

  // Two-flop synchronizer; idle level is 1 (released, active-low keys).
  // NOTE: flops use non-blocking assignments and reset synchronously inside the clocked block; this design has no memories, so every register is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= KEY;
      sync2_q <= sync1_q;
    end
  end

  assign ks = ~sync2_q;

  for (genvar i = 0; i < 2; i++) begin : g_deb
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deb_q, deb_d;
    logic             press_c;

    // Debouncer state, counter and accepted level.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_STABLE;
        cnt_q   <= '0;
        deb_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        deb_q   <= deb_d;
      end
    end

    // Next-state: a level change is accepted only after an unbroken run of
    // mismatching samples; any match in between rejects it as a glitch.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      deb_d   = deb_q;
      press_c = 1'b0;
      unique case (state_q)
        ST_STABLE: begin
          if (ks[i] != deb_q) begin
            cnt_d   = '0;
            state_d = ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (ks[i] == deb_q) begin
            state_d = ST_STABLE;
          end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            deb_d   = ~deb_q;
            state_d = ST_COMMIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_COMMIT: begin
          press_c = deb_q;  // releases commit silently
          state_d = ST_STABLE;
        end
        default: state_d = ST_STABLE;
      endcase
    end

    assign press[i] = press_c;
    assign deb[i]   = deb_q;
  end

`ifdef ULA_AUTO_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);

  logic [REP_W-1:0] rep_q, rep_d;

  // Hold timer for KEY[0]; restarts on the commit cycle and on release.
  always_comb begin
    rep_d       = rep_q;
    repeat_step = 1'b0;
    if (!deb[0] || press[0]) begin
      rep_d = '0;
    end else if (rep_q == REP_W'(REPEAT_CYCLES - 1)) begin
      rep_d       = '0;
      repeat_step = 1'b1;
    end else begin
      rep_d = rep_q + 1'b1;
    end
  end

  // Hold timer register.
  always_ff @(posedge clk) begin
    if (rst) rep_q <= '0;
    else     rep_q <= rep_d;
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_CYCLES > 0);
  assign repeat_step       = 1'b0;
`endif

  assign step = press[0] | repeat_step;

  logic [2:0] sel_q, sel_d;
  logic [3:0] a_q, b_q;
  logic       cin_q, op_q, load_q;

  // Selector advances 0..6 and wraps straight back to 0.
  always_comb begin
    sel_d = sel_q;
    if (step) sel_d = (sel_q == 3'd6) ? 3'd0 : sel_q + 3'd1;
  end

  // Output registers; switches are sampled only on a KEY[1] press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= 3'd0;
      a_q    <= 4'd0;
      b_q    <= 4'd0;
      cin_q  <= 1'b0;
      op_q   <= 1'b0;
      load_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      op_q   <= step;
      load_q <= press[1];
      if (press[1]) begin
        a_q   <= SW[3:0];
        b_q   <= SW[7:4];
        cin_q <= SW[8];
      end
    end
  end

  logic unused_sw9;
  assign unused_sw9 = SW[9];

  assign a_out       = a_q;
  assign b_out       = b_q;
  assign cin_out     = cin_q;
  assign seletor_out = sel_q;
  assign op_pulse    = op_q;
  assign load_pulse  = load_q;

endmodule
